// File: rtl/sm_add_pkg.sv
// Shared types and constants for the sign-magnitude adder arbiter.
// A sign-magnitude word keeps the sign in its MSB and the magnitude below it.
// The typedefs here match the default build. The modules take W, N_REQ and
// IDW as parameters, and those parameters default to the values below.
package sm_add_pkg;

  localparam int SM_W     = 4;
  localparam int SM_N_REQ = 4;
  localparam int SM_IDW   = $clog2(SM_N_REQ);

  typedef logic [SM_W-1:0]   sm_word_t;
  typedef logic [SM_W-2:0]   sm_mag_t;
  typedef logic [SM_IDW-1:0] req_id_t;

  // IDLE: the output register is empty. HOLD: a result is presented downstream.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // The canonical zero. Negative zero is never produced.
  localparam sm_word_t SM_POS_ZERO = '0;

endpackage : sm_add_pkg

// File: rtl/sm_add_core.sv
// Combinational sign-magnitude adder: (a, b) -> (sum, ovf).
// - Same signs: the magnitudes are added, and ovf is the carry out of the
//   magnitude field.
// - Different signs: the smaller magnitude is subtracted from the larger one.
//   The sign comes from the larger operand. On a tie the sign comes from B.
// - A zero-magnitude result is always +0. A -0 input behaves as +0.
// Optional build macro: SM_ADD_SAT_EN. When it is defined, an overflowing
// magnitude saturates to all ones. Otherwise the magnitude wraps to its low
// bits. ovf is flagged in both cases.
module sm_add_core
  import sm_add_pkg::*;
#(
  parameter int W = SM_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);

  localparam int M = W - 1;

  logic [M-1:0] w_ma;
  logic [M-1:0] w_mb;
  logic         w_sa;
  logic         w_sb;
  logic [M:0]   w_add;
  logic [M-1:0] w_mag;
  logic         w_sign;
  logic         w_ovf;

  // Add or subtract the magnitudes, then apply the saturation and zero-sign rules.
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch can be inferred.
    w_mag  = '0;
    w_sign = 1'b0;
    w_ovf  = 1'b0;

    w_ma  = i_a[M-1:0];
    w_mb  = i_b[M-1:0];
    // A -0 input is normalised to +0 before the signs are compared.
    w_sa  = i_a[W-1] & (|w_ma);
    w_sb  = i_b[W-1] & (|w_mb);
    w_add = {1'b0, w_ma} + {1'b0, w_mb};

    if (w_sa == w_sb) begin
      w_mag  = w_add[M-1:0];
      w_ovf  = w_add[M];
      w_sign = w_sa;
    end else if (w_ma > w_mb) begin
      w_mag  = w_ma - w_mb;
      w_sign = w_sa;
    end else begin
      // This branch also covers equal magnitudes, where the sign comes from B.
      w_mag  = w_mb - w_ma;
      w_sign = w_sb;
    end

`ifdef SM_ADD_SAT_EN
    if (w_ovf) begin
      w_mag = '1;
    end
`endif

    // Any zero magnitude is reported as +0.
    if (w_mag == '0) begin
      w_sign = 1'b0;
    end
  end

  assign o_sum = {w_sign, w_mag};
  assign o_ovf = w_ovf;

endmodule : sm_add_core

// File: rtl/sm_add_arbiter.sv
// Round-robin arbiter that shares one sign-magnitude adder among N_REQ
// requesters.
// - The grant goes to the first valid requester after the last-grant pointer,
//   searching with wrap-around.
// - The accepted operands are summed and registered.
// - The result is held downstream, with the winner's ID, until res_ready is high.
// - Back-to-back accepts sustain one result per cycle.
// Optional build macro: SM_ADD_SAT_EN (saturating overflow inside sm_add_core).
module sm_add_arbiter
  import sm_add_pkg::*;
#(
  parameter int W     = SM_W,
  parameter int N_REQ = SM_N_REQ,
  parameter int IDW   = SM_IDW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [W-1:0]       res_sum,
  output logic [IDW-1:0]     res_id,
  output logic               res_ovf
);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_ptr;
  logic [W-1:0]   r_sum;
  logic [IDW-1:0] r_id;
  logic           r_ovf;

  logic           w_gnt_found;
  logic [IDW-1:0] w_gnt_id;
  logic [IDW-1:0] w_idx;
  logic           w_can_accept;
  logic           w_xfer;
  logic [W-1:0]   w_op_a;
  logic [W-1:0]   w_op_b;
  logic [W-1:0]   w_core_sum;
  logic           w_core_ovf;

  // Round-robin search that starts at the requester after the last grant.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    w_idx       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % N_REQ);
      if (!w_gnt_found && req_valid[w_idx]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = w_idx;
      end
    end
  end

  // Route the granted requester's operand pair to the shared adder.
  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_id == IDW'(i)) begin
        w_op_a = req_a[i*W +: W];
        w_op_b = req_b[i*W +: W];
      end
    end
  end

  sm_add_core #(
    .W(W)
  ) u_core (
    .i_a  (w_op_a),
    .i_b  (w_op_b),
    .o_sum(w_core_sum),
    .o_ovf(w_core_ovf)
  );

  // Accept a request while the output register is empty or being drained.
  // Holding reset masks every ready, so no handshake can happen during reset.
  always_comb begin
    w_can_accept = rst_n && ((r_state == IDLE) || res_ready);
    w_xfer       = w_can_accept && w_gnt_found;
    req_ready    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = w_xfer && (w_gnt_id == IDW'(i));
    end

    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_xfer) w_state_nxt = HOLD;
      HOLD: begin
        if (w_xfer)         w_state_nxt = HOLD;
        else if (res_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Last-grant pointer. After reset it makes requester 0 the highest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ptr <= IDW'(N_REQ - 1);
    else if (w_xfer) r_ptr <= w_gnt_id;
  end

  // Output register. It loads only on a transfer, so under backpressure it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath registers are reset as well, so the downstream outputs read a clean +0 after reset.
    if (!rst_n) begin
      r_sum <= W'(SM_POS_ZERO);
      r_id  <= '0;
      r_ovf <= 1'b0;
    end else if (w_xfer) begin
      r_sum <= w_core_sum;
      r_id  <= w_gnt_id;
      r_ovf <= w_core_ovf;
    end
  end

  assign res_valid = (r_state == HOLD);
  assign res_sum   = r_sum;
  assign res_id    = r_id;
  assign res_ovf   = r_ovf;

endmodule : sm_add_arbiter

// File: tb/tb_sm_add_arbiter.sv
// Self-checking bench for sm_add_arbiter.
// It applies directed arithmetic vectors, fairness, backpressure and reset
// sequences, then randomized traffic checked against a transaction-level
// model. The model computes sums with signed integers.
`timescale 1ns/1ps
module tb_sm_add_arbiter;

  localparam int W   = 4;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int MAXMAG = (2 ** (W - 1)) - 1;
`ifdef SM_ADD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           val_arr [N];
  logic [W-1:0]   a_arr   [N];
  logic [W-1:0]   b_arr   [N];
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [W-1:0]   res_sum;
  logic [IDW-1:0] res_id;
  logic           res_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always_comb begin
    req_valid = {val_arr[3], val_arr[2], val_arr[1], val_arr[0]};
    req_a     = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
    req_b     = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};
  end

  sm_add_arbiter #(.W(W), .N_REQ(N), .IDW(IDW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_ready(req_ready),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_sum  (res_sum),
    .res_id   (res_id),
    .res_ovf  (res_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference adder: sign-magnitude -> integer, add, then convert back.
  function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] sum, output logic ovf);
    int va, vb, s, mag;
    va  = a[W-1] ? -int'(a[W-2:0]) : int'(a[W-2:0]);
    vb  = b[W-1] ? -int'(b[W-2:0]) : int'(b[W-2:0]);
    s   = va + vb;
    mag = (s < 0) ? -s : s;
    ovf = (mag > MAXMAG);
    if (ovf) mag = SAT ? MAXMAG : (mag % (MAXMAG + 1));
    sum = {((s < 0) && (mag != 0)) ? 1'b1 : 1'b0, (W-1)'(mag)};
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      val_arr[i] = 1'b0;
      a_arr[i]   = '0;
      b_arr[i]   = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         ovf;
  } vec_t;

  vec_t vecs [10];

  logic [W-1:0] f_sum [N];
  logic         f_ovf [N];

  initial begin
    logic [W-1:0] m_sum;
    logic         m_ovf;
    logic [IDW-1:0] m_id;
    bit           pend;
    int           ptr;
    int           g;
    bit           can;
    logic [N-1:0] exp_rdy;
    bit           acc [N];

    vecs[0] = '{4'b0011, 4'b0010, 4'b0101, 1'b0};
    vecs[1] = '{4'b0011, 4'b1101, 4'b1010, 1'b0};
    vecs[2] = '{4'b0101, 4'b1101, 4'b0000, 1'b0};
    vecs[3] = '{4'b0110, 4'b0011, SAT ? 4'b0111 : 4'b0001, 1'b1};
    vecs[4] = '{4'b1110, 4'b1011, SAT ? 4'b1111 : 4'b1001, 1'b1};
    vecs[5] = '{4'b1000, 4'b0000, 4'b0000, 1'b0};
    vecs[6] = '{4'b1100, 4'b0100, 4'b0000, 1'b0};
    vecs[7] = '{4'b0001, 4'b1011, 4'b1010, 1'b0};
    vecs[8] = '{4'b1100, 4'b1100, SAT ? 4'b1111 : 4'b0000, 1'b1};
    vecs[9] = '{4'b1000, 4'b0111, 4'b0111, 1'b0};

    // Reset values, with every requester asking: no ready may rise.
    clear_inputs();
    rst_n = 1'b0;
    #12;
    for (int i = 0; i < N; i++) val_arr[i] = 1'b1;
    #1;
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_sum",   32'(res_sum),   32'd0);
    check("rst_id",    32'(res_id),    32'd0);
    check("rst_ovf",   32'(res_ovf),   32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic vectors, each one a single request on requester 0.
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      val_arr[0] = 1'b1;
      a_arr[0]   = vecs[v].a;
      b_arr[0]   = vecs[v].b;
      res_ready  = 1'b1;
      #1;
      check($sformatf("vec%0d_ready", v), 32'(req_ready), 32'd1);
      @(negedge clk);
      check($sformatf("vec%0d_valid", v), 32'(res_valid), 32'd1);
      check($sformatf("vec%0d_sum", v),   32'(res_sum),   32'(vecs[v].sum));
      check($sformatf("vec%0d_id", v),    32'(res_id),    32'd0);
      check($sformatf("vec%0d_ovf", v),   32'(res_ovf),   32'(vecs[v].ovf));
      val_arr[0] = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_idle", v), 32'(res_valid), 32'd0);
    end

    // Fairness: all four requesters valid, no backpressure, starting from reset.
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_arr[i]   = W'($urandom);
      b_arr[i]   = W'($urandom);
      val_arr[i] = 1'b1;
      ref_add(a_arr[i], b_arr[i], f_sum[i], f_ovf[i]);
    end
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        @(negedge clk);
        check($sformatf("fair%0d_valid", k), 32'(res_valid), 32'd1);
        check($sformatf("fair%0d_id", k),    32'(res_id),    32'((k - 1) % N));
        check($sformatf("fair%0d_sum", k),   32'(res_sum),   32'(f_sum[(k - 1) % N]));
        check($sformatf("fair%0d_ovf", k),   32'(res_ovf),   32'(f_ovf[(k - 1) % N]));
      end
      #1;
      check($sformatf("fair%0d_ready", k), 32'(req_ready), 32'(1 << (k % N)));
    end

    // Backpressure: the result of requester 0 must hold for five cycles.
    @(negedge clk);
    check("bp_id0", 32'(res_id), 32'd0);
    res_ready = 1'b0;
    #1;
    check("bp_ready0", 32'(req_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d_valid", k), 32'(res_valid), 32'd1);
      check($sformatf("bp%0d_sum", k),   32'(res_sum),   32'(f_sum[0]));
      check($sformatf("bp%0d_id", k),    32'(res_id),    32'd0);
      check($sformatf("bp%0d_ready", k), 32'(req_ready), 32'd0);
    end
    res_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'd2);
    @(negedge clk);
    check("bp_next_id",  32'(res_id),  32'd1);
    check("bp_next_sum", 32'(res_sum), 32'(f_sum[1]));
    clear_inputs();
    #1;
    check("drain_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("drain_idle", 32'(res_valid), 32'd0);

    // Asynchronous reset while HOLD is active.
    val_arr[2] = 1'b1;
    a_arr[2]   = 4'b0001;
    b_arr[2]   = 4'b0001;
    res_ready  = 1'b0;
    #1;
    check("hold_ready2", 32'(req_ready), 32'd4);
    @(negedge clk);
    check("hold_valid", 32'(res_valid), 32'd1);
    check("hold_id",    32'(res_id),    32'd2);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) val_arr[i] = 1'b1;
    #1;
    check("async_rst_valid", 32'(res_valid), 32'd0);
    check("async_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    res_ready = 1'b1;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("post_rst_id",    32'(res_id),    32'd0);
    check("post_rst_valid", 32'(res_valid), 32'd1);

    // Randomized traffic against the transaction-level model.
    do_reset();
    pend  = 1'b0;
    ptr   = N - 1;
    m_sum = '0;
    m_ovf = 1'b0;
    m_id  = '0;
    for (int i = 0; i < N; i++) acc[i] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      check("rnd_valid", 32'(res_valid), 32'(pend));
      if (pend) begin
        check("rnd_sum", 32'(res_sum), 32'(m_sum));
        check("rnd_id",  32'(res_id),  32'(m_id));
        check("rnd_ovf", 32'(res_ovf), 32'(m_ovf));
      end
      for (int i = 0; i < N; i++) begin
        if (val_arr[i] && !acc[i]) begin
          // A waiting requester keeps its operands. It may withdraw, though.
          if ($urandom_range(0, 4) == 0) val_arr[i] = 1'b0;
        end else begin
          val_arr[i] = ($urandom_range(0, 1) == 1);
          a_arr[i]   = W'($urandom);
          b_arr[i]   = W'($urandom);
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      can = !pend || res_ready;
      g   = -1;
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && val_arr[(ptr + k) % N]) g = (ptr + k) % N;
      end
      exp_rdy = (can && g >= 0) ? N'(1 << g) : '0;
      check("rnd_ready", 32'(req_ready), 32'(exp_rdy));
      for (int i = 0; i < N; i++) acc[i] = 1'b0;
      if (can && g >= 0) begin
        acc[g] = 1'b1;
        ref_add(a_arr[g], b_arr[g], m_sum, m_ovf);
        m_id = IDW'(g);
        pend = 1'b1;
        ptr  = g;
      end else if (pend && res_ready) begin
        pend = 1'b0;
      end
    end
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sm_add_arbiter
